// File: rtl/acia_bus_arbiter.sv
// acia_bus_arbiter
// Two requesters share one ACIA register port: m0 (CPU bus bridge) and
// m1 (monitor/message streamer). Arbitration is round-robin. Every granted
// access produces exactly one single-cycle acia_en strobe, because reading
// the data register pops the ACIA receive FIFO. An owner may hold a lock to
// run atomic sequences; a watchdog forces release if it idles too long.
//
// Ports
//   clk, rst                 system clock, async active-low reset
//   mN_req/lock/we/rs/din    requester N access request and fields
//   mN_ack, mN_rdata         requester N completion pulse and read data
//   acia_en/we/rs/din        ACIA register port strobe, direction, address, data
//   acia_dout                ACIA read data (combinational from the ACIA)
//   owner                    00 none, 01 m0, 10 m1
//   lock_timeout             one-cycle pulse on watchdog release
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no owner; grant a pending request (priority master on a tie)
// S_ACCESS | acia_en strobe for the captured access; sample acia_dout
// S_ACK    | ack the owner; keep ownership if its lock is high
// S_LOCKED | only the owner may issue; watchdog counts idle cycles
module acia_bus_arbiter #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter bit RESET_PRIO   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m0_lock,
  input  logic       m0_we,
  input  logic [1:0] m0_rs,
  input  logic [7:0] m0_din,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_lock,
  input  logic       m1_we,
  input  logic [1:0] m1_rs,
  input  logic [7:0] m1_din,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       acia_en,
  output logic       acia_we,
  output logic [1:0] acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  output logic [1:0] owner,
  output logic       lock_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  localparam int TW     = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int TC_INT = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;
  localparam logic [TW-1:0] TIMER_TC = TW'(TC_INT);

  state_t          state_q, state_d;
  logic            prio_q, prio_d;   // 0 = m0 wins a tie, 1 = m1 wins
  logic            own_q, own_d;     // current owner index, meaningful outside S_IDLE
  logic [TW-1:0]   timer_q, timer_d;
  logic            we_q;
  logic [1:0]      rs_q;
  logic [7:0]      din_q;
  logic [7:0]      rdata0_q, rdata1_q;
  logic            capture;
  logic            own_req, own_lock;
  logic            sel_we;
  logic [1:0]      sel_rs;
  logic [7:0]      sel_din;

  assign own_req  = own_q ? m1_req  : m0_req;
  assign own_lock = own_q ? m1_lock : m0_lock;

  // Capture always takes the fields of the master being (re)granted.
  assign sel_we  = own_d ? m1_we  : m0_we;
  assign sel_rs  = own_d ? m1_rs  : m0_rs;
  assign sel_din = own_d ? m1_din : m0_din;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    own_d        = own_q;
    timer_d      = timer_q;
    capture      = 1'b0;
    lock_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          own_d   = (m0_req && m1_req) ? prio_q : m1_req;
          capture = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (own_lock) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
          prio_d  = ~own_q;
        end
      end
      S_LOCKED: begin
        if (own_req) begin
          capture = 1'b1;
          state_d = S_ACCESS;
          timer_d = '0;
        end else if (!own_lock) begin
          state_d = S_IDLE;
          prio_d  = ~own_q;
        end else if ((LOCK_TIMEOUT != 0) && (timer_q == TIMER_TC)) begin
          state_d      = S_IDLE;
          prio_d       = ~own_q;
          lock_timeout = 1'b1;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prio_q   <= RESET_PRIO;
      own_q    <= 1'b0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      rs_q     <= 2'b00;
      din_q    <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      own_q   <= own_d;
      timer_q <= timer_d;
      if (capture) begin
        we_q  <= sel_we;
        rs_q  <= sel_rs;
        din_q <= sel_din;
      end
      if (state_q == S_ACCESS) begin
        if (own_q) rdata1_q <= we_q ? 8'h00 : acia_dout;
        else       rdata0_q <= we_q ? 8'h00 : acia_dout;
      end
    end
  end

  assign acia_en  = (state_q == S_ACCESS);
  assign acia_we  = (state_q == S_ACCESS) && we_q;
  assign acia_rs  = rs_q;
  assign acia_din = din_q;
  assign m0_ack   = (state_q == S_ACK) && !own_q;
  assign m1_ack   = (state_q == S_ACK) &&  own_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign owner    = (state_q == S_IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_acia_bus_arbiter.sv
module tb_acia_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m0_lock, m0_we;
  logic [1:0] m0_rs;
  logic [7:0] m0_din;
  logic       m0_ack;
  logic [7:0] m0_rdata;
  logic       m1_req, m1_lock, m1_we;
  logic [1:0] m1_rs;
  logic [7:0] m1_din;
  logic       m1_ack;
  logic [7:0] m1_rdata;
  logic       acia_en, acia_we;
  logic [1:0] acia_rs;
  logic [7:0] acia_din, acia_dout;
  logic [1:0] owner;
  logic       lock_timeout;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acia_bus_arbiter #(.LOCK_TIMEOUT(8), .RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_rs(m0_rs), .m0_din(m0_din),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_rs(m1_rs), .m1_din(m1_din),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .acia_en(acia_en), .acia_we(acia_we), .acia_rs(acia_rs), .acia_din(acia_din),
    .acia_dout(acia_dout), .owner(owner), .lock_timeout(lock_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_rs = 2'b00; m0_din = 8'h00;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_rs = 2'b00; m1_din = 8'h00;
    acia_dout = 8'h00;
  endtask

  task automatic do_reset();
    tick();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_run++; if (acia_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", acia_en); end
    n_run++; if (acia_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", acia_we); end
    n_run++; if ({acia_rs, acia_din} !== 10'h000) begin n_fail++; $display("FAIL reset_rs_din: got %h want 000", {acia_rs, acia_din}); end
    n_run++; if (owner !== 2'b00) begin n_fail++; $display("FAIL reset_owner: got %b want 00", owner); end
    n_run++; if ({m0_ack, m1_ack, lock_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {m0_ack, m1_ack, lock_timeout}); end
    n_run++; if ({m0_rdata, m1_rdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {m0_rdata, m1_rdata}); end
  endtask

  task automatic test_single_read();
    do_reset();
    tick(); m0_req = 1; m0_we = 0; m0_rs = 2'b01; acia_dout = 8'h18;
    @(negedge clk);
    n_run++; if ({acia_en, owner} !== 3'b000) begin n_fail++; $display("FAIL rd_n_idle: got en/owner %b want 000", {acia_en, owner}); end
    tick();
    @(negedge clk);
    n_run++; if ({acia_en, acia_we, acia_rs} !== 4'b1001) begin n_fail++; $display("FAIL rd_n1_strobe: got en/we/rs %b want 1001", {acia_en, acia_we, acia_rs}); end
    n_run++; if ({owner, m0_ack} !== 3'b010) begin n_fail++; $display("FAIL rd_n1_owner: got owner/ack %b want 010", {owner, m0_ack}); end
    tick();
    @(negedge clk);
    n_run++; if ({m0_ack, acia_en, m1_ack} !== 3'b100) begin n_fail++; $display("FAIL rd_n2_ack: got ack/en/m1ack %b want 100", {m0_ack, acia_en, m1_ack}); end
    n_run++; if (m0_rdata !== 8'h18) begin n_fail++; $display("FAIL rd_n2_rdata: got %h want 18", m0_rdata); end
    tick(); m0_req = 0; acia_dout = 8'h00;
    @(negedge clk);
    n_run++; if ({owner, m0_ack, acia_en} !== 4'b0000) begin n_fail++; $display("FAIL rd_release: got owner/ack/en %b want 0000", {owner, m0_ack, acia_en}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_run++; if (acia_en !== 1'b0) begin n_fail++; $display("FAIL rd_no_extra_en: cycle %0d got %b want 0", c, acia_en); end
    end
  endtask

  task automatic test_contention();
    logic       exp_en;
    logic [1:0] exp_owner;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        m0_req = 1; m0_rs = 2'b00; acia_dout = 8'h42;
        m1_req = 1; m1_rs = 2'b10;
      end
      @(negedge clk);
      exp_en    = ((c % 3) == 1);
      exp_owner = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
      n_run++; if (acia_en !== exp_en) begin n_fail++; $display("FAIL rr_en: cycle %0d got %b want %b", c, acia_en, exp_en); end
      if (exp_en) begin
        n_run++; if (owner !== exp_owner) begin n_fail++; $display("FAIL rr_owner: cycle %0d got %b want %b", c, owner, exp_owner); end
      end
      if ((c % 3) == 2) begin
        n_run++; if ({m0_ack, m1_ack} !== {exp_owner == 2'b01, exp_owner == 2'b10}) begin
          n_fail++; $display("FAIL rr_ack: cycle %0d got m0/m1 %b want %b", c, {m0_ack, m1_ack}, {exp_owner == 2'b01, exp_owner == 2'b10});
        end
      end
    end
  endtask

  task automatic test_locked_sequence();
    int m1_strobes;
    m1_strobes = 0;
    do_reset();
    tick(); m1_req = 1; m1_lock = 1; m1_we = 0; m1_rs = 2'b01;
    @(negedge clk);
    tick(); m0_req = 1; m0_rs = 2'b00; acia_dout = 8'h55;
    @(negedge clk);
    if (acia_en && owner == 2'b10) m1_strobes++;
    n_run++; if ({acia_en, owner, acia_rs} !== 5'b11001) begin n_fail++; $display("FAIL lk_first: got en/owner/rs %b want 11001", {acia_en, owner, acia_rs}); end
    tick();
    @(negedge clk);
    n_run++; if ({m1_ack, m0_ack, m1_rdata} !== 10'b10_0101_0101) begin n_fail++; $display("FAIL lk_first_ack: got %b want 1001010101", {m1_ack, m0_ack, m1_rdata}); end
    tick(); m1_rs = 2'b00; m1_lock = 0;
    @(negedge clk);
    n_run++; if ({acia_en, owner} !== 3'b010) begin n_fail++; $display("FAIL lk_hold: got en/owner %b want 010", {acia_en, owner}); end
    tick(); acia_dout = 8'hA7;
    @(negedge clk);
    if (acia_en && owner == 2'b10) m1_strobes++;
    n_run++; if ({acia_en, owner, acia_rs} !== 5'b11000) begin n_fail++; $display("FAIL lk_second: got en/owner/rs %b want 11000", {acia_en, owner, acia_rs}); end
    tick();
    @(negedge clk);
    n_run++; if ({m1_ack, m1_rdata} !== 9'b1_1010_0111) begin n_fail++; $display("FAIL lk_second_ack: got %b want 110100111", {m1_ack, m1_rdata}); end
    tick(); m1_req = 0;
    @(negedge clk);
    if (acia_en && owner == 2'b10) m1_strobes++;
    n_run++; if (acia_en !== 1'b0) begin n_fail++; $display("FAIL lk_gap: got en %b want 0", acia_en); end
    tick();
    @(negedge clk);
    n_run++; if ({acia_en, owner} !== 3'b101) begin n_fail++; $display("FAIL lk_m0_after: got en/owner %b want 101", {acia_en, owner}); end
    n_run++; if (m1_strobes !== 2) begin n_fail++; $display("FAIL lk_strobe_count: got %0d want 2", m1_strobes); end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    tick(); m0_req = 1; m0_lock = 1; m0_rs = 2'b01;
    @(negedge clk);
    tick(); m1_req = 1; m1_rs = 2'b00;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_run++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL to_ack: got %b want 1", m0_ack); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) m0_req = 0;
      @(negedge clk);
      n_run++; if (lock_timeout !== (k == 8)) begin n_fail++; $display("FAIL to_pulse: ack+%0d got %b want %b", k, lock_timeout, k == 8); end
      n_run++; if ({acia_en, owner} !== 3'b001) begin n_fail++; $display("FAIL to_locked: ack+%0d got en/owner %b want 001", k, {acia_en, owner}); end
    end
    tick(); m0_lock = 0;
    @(negedge clk);
    n_run++; if ({owner, lock_timeout, acia_en} !== 4'b0000) begin n_fail++; $display("FAIL to_release: got owner/pulse/en %b want 0000", {owner, lock_timeout, acia_en}); end
    tick();
    @(negedge clk);
    n_run++; if ({acia_en, owner} !== 3'b110) begin n_fail++; $display("FAIL to_m1_grant: got en/owner %b want 110", {acia_en, owner}); end
  endtask

  task automatic test_write();
    do_reset();
    tick(); m1_req = 1; m1_we = 1; m1_rs = 2'b11; m1_din = 8'h0E; acia_dout = 8'hFF;
    @(negedge clk);
    n_run++; if (acia_we !== 1'b0) begin n_fail++; $display("FAIL wr_we_idle: got %b want 0", acia_we); end
    tick(); m1_din = 8'h33; m1_rs = 2'b01; m1_we = 0;
    @(negedge clk);
    n_run++; if ({acia_en, acia_we, acia_rs, acia_din} !== 12'b1_1_11_0000_1110) begin n_fail++; $display("FAIL wr_strobe: got en/we/rs/din %b want 111100001110", {acia_en, acia_we, acia_rs, acia_din}); end
    tick();
    @(negedge clk);
    n_run++; if ({m1_ack, m1_rdata} !== 9'b1_0000_0000) begin n_fail++; $display("FAIL wr_ack: got ack/rdata %b want 100000000", {m1_ack, m1_rdata}); end
    n_run++; if ({acia_en, acia_we} !== 2'b00) begin n_fail++; $display("FAIL wr_we_after: got en/we %b want 00", {acia_en, acia_we}); end
    tick(); m1_req = 0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    tick(); m0_req = 1; m0_rs = 2'b10; acia_dout = 8'h77;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_run++; if (acia_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_en: got %b want 1", acia_en); end
    #1 rst = 0; m0_req = 0;
    #1;
    n_run++; if ({acia_en, owner, m0_ack, m1_ack} !== 5'b00000) begin n_fail++; $display("FAIL mid_async: got en/owner/acks %b want 00000", {acia_en, owner, m0_ack, m1_ack}); end
    tick();
    tick(); rst = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_run++; if ({acia_en, m0_ack, m1_ack} !== 3'b000) begin n_fail++; $display("FAIL mid_quiet: cycle %0d got en/acks %b want 000", c, {acia_en, m0_ack, m1_ack}); end
      tick();
    end
    m0_req = 1;
    tick();
    @(negedge clk);
    n_run++; if ({acia_en, owner} !== 3'b101) begin n_fail++; $display("FAIL mid_regrant: got en/owner %b want 101", {acia_en, owner}); end
    tick();
    @(negedge clk);
    n_run++; if ({m0_ack, m0_rdata} !== 9'b1_0111_0111) begin n_fail++; $display("FAIL mid_regrant_ack: got %b want 101110111", {m0_ack, m0_rdata}); end
    tick(); m0_req = 0;
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_locked_sequence();
    test_lock_timeout();
    test_write();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
